// File: rtl/divider_sequencer.sv
// divider_sequencer
// Sequences an external programmable clock divider through a queue of steps.
// Each step is a (divide, count) pair: the divider is loaded with the divide
// factor, released from reset, and the step ends once the divided clock has
// toggled `count` times. Steps run back-to-back while the queue is non-empty.
//
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   in_valid/in_ready step push handshake
//   in_divide         divide factor of the pushed step (0 is stored as 1)
//   in_count          divided-clock toggles the pushed step lasts
//   div_divide_by     divide factor driven to the external divider
//   div_reset         reset driven to the external divider
//   div_clk_out       divided clock returned by the external divider
//   busy              a step is loading or running
//   done              one-cycle pulse when a step completes
//   fifo_level        queued steps, not counting the running one
//   abort             (only with DIVSEQ_ABORT_EN) drop running and queued steps
//
// Optional feature macro: DIVSEQ_ABORT_EN adds the abort input.
//
// state | meaning
// IDLE  | divider held in reset, waiting for a queued step
// LOAD  | one cycle: divide factor applied, divider still in reset
// RUN   | divider running, counting divided-clock toggles

module divider_sequencer #(
    parameter int DEPTH = 4,
    parameter int CW    = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_divide,
    input  logic [CW-1:0]            in_count,
    output logic [15:0]              div_divide_by,
    output logic                     div_reset,
    input  logic                     div_clk_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef DIVSEQ_ABORT_EN
    ,
    input  logic                     abort
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state, state_n;
    logic [15:0]     mem_div [DEPTH];
    logic [CW-1:0]   mem_cnt [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level;
    logic [15:0]     div_q;
    logic [CW-1:0]   run_cnt;
    logic [CW-1:0]   tcnt;
    logic [CW-1:0]   cnt_inc;
    logic            clk_prev;
    logic            toggle;
    logic            full, empty;
    logic            push, pop;
    logic            done_n, done_q;
    logic            clr_cnt, inc_cnt;
    logic            abort_i;

`ifdef DIVSEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign toggle  = div_clk_out ^ clk_prev;
    assign cnt_inc = tcnt + 1'b1;

    // in_ready reflects only the fill level; a push offered while full is
    // still taken when the same edge pops the head, so the slot is reused.
    assign in_ready = ~full;
    assign push     = in_valid & (~full | pop) & ~abort_i;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        done_n  = 1'b0;
        clr_cnt = 1'b0;
        inc_cnt = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                clr_cnt = 1'b1;
                if (run_cnt == '0) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (toggle) begin
                    if (cnt_inc == run_cnt) begin
                        done_n = 1'b1;
                        if (!empty) begin
                            pop     = 1'b1;
                            state_n = LOAD;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        inc_cnt = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort_i) begin
            state_n = IDLE;
            pop     = 1'b0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            div_q    <= 16'd1;
            run_cnt  <= '0;
            tcnt     <= '0;
            clk_prev <= 1'b0;
        end else begin
            state    <= state_n;
            done_q   <= done_n;
            clk_prev <= div_clk_out;
            if (pop) begin
                div_q   <= mem_div[rd_ptr];
                run_cnt <= mem_cnt[rd_ptr];
            end
            if (clr_cnt || abort_i) begin
                tcnt <= '0;
            end else if (inc_cnt) begin
                tcnt <= cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_div[wr_ptr] <= (in_divide == 16'd0) ? 16'd1 : in_divide;
            mem_cnt[wr_ptr] <= in_count;
        end
    end

    assign busy          = (state != IDLE);
    assign div_reset     = (state != RUN);
    assign div_divide_by = div_q;
    assign done          = done_q;
    assign fifo_level    = level;

endmodule

// File: tb/tb_divider_sequencer.sv
// Testbench for divider_sequencer: table of single steps with hand-computed
// done latencies, plus sequences for back-to-back queueing, full-queue
// push/pop, reset mid-run and (when DIVSEQ_ABORT_EN is defined) abort.

module tb_divider_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = 12;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_divide = 16'd0;
    logic [CW-1:0]     in_count = '0;
    logic [15:0]       div_divide_by;
    logic              div_reset;
    logic              div_clk_out;
    logic              busy;
    logic              done;
    logic [2:0]        fifo_level;
`ifdef DIVSEQ_ABORT_EN
    logic              abort = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    divider_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_divide     (in_divide),
        .in_count      (in_count),
        .div_divide_by (div_divide_by),
        .div_reset     (div_reset),
        .div_clk_out   (div_clk_out),
        .busy          (busy),
        .done          (done),
        .fifo_level    (fifo_level)
`ifdef DIVSEQ_ABORT_EN
        ,
        .abort         (abort)
`endif
    );

    always #5 clk = ~clk;

    // External divider model: held clear while div_reset is high, toggles its
    // output every div_divide_by cycles once released.
    logic [15:0] dcnt;
    logic        dout;
    always @(posedge clk or posedge div_reset) begin
        if (div_reset) begin
            dcnt <= 16'd0;
            dout <= 1'b0;
        end else if (dcnt == div_divide_by - 16'd1) begin
            dcnt <= 16'd0;
            dout <= ~dout;
        end else begin
            dcnt <= dcnt + 16'd1;
        end
    end
    assign div_clk_out = dout;

    // Sequence monitor for the back-to-back test.
    logic        mon_en = 1'b0;
    logic        mon_started;
    int          done_cnt;
    int          gaps;
    logic [15:0] load_q [$];
    always @(negedge clk) begin
        if (!mon_en) begin
            mon_started <= 1'b0;
            done_cnt    <= 0;
            gaps        <= 0;
        end else begin
            if (busy) mon_started <= 1'b1;
            if (busy && div_reset) load_q.push_back(div_divide_by);
            if (!busy && mon_started && (done_cnt + (done ? 1 : 0)) < 6) gaps <= gaps + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [15:0]   divide;
        logic [CW-1:0] count;
        logic [15:0]   exp_div;
        int            exp_done;   // cycles after first RUN cycle; -1 = right after LOAD
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int i);
        int n;
        in_divide = vecs[i].divide;
        in_count  = vecs[i].count;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        check($sformatf("v%0d_load_busy", i), busy, 1);
        check($sformatf("v%0d_load_div_reset", i), div_reset, 1);
        check($sformatf("v%0d_load_div", i), div_divide_by, vecs[i].exp_div);
        tick();
        if (vecs[i].exp_done < 0) begin
            check($sformatf("v%0d_zero_done", i), done, 1);
            check($sformatf("v%0d_zero_busy", i), busy, 0);
        end else begin
            check($sformatf("v%0d_run_div_reset", i), div_reset, 0);
            check($sformatf("v%0d_run_div", i), div_divide_by, vecs[i].exp_div);
            n = 0;
            while (!done && n < 5000) begin
                tick();
                n++;
            end
            check($sformatf("v%0d_done_delay", i), n, vecs[i].exp_done);
            check($sformatf("v%0d_done_busy", i), busy, 0);
        end
        tick();
        check($sformatf("v%0d_done_pulse", i), done, 0);
        check($sformatf("v%0d_idle_div_hold", i), div_divide_by, vecs[i].exp_div);
        check($sformatf("v%0d_idle_div_reset", i), div_reset, 1);
    endtask

    logic [15:0]   sdiv [6];
    logic [CW-1:0] scnt [6];

    initial begin
        int n;
        int bad;
        vecs[0] = '{16'd4, 12'd3,   16'd4, 13};
        vecs[1] = '{16'd0, 12'd2,   16'd1, 3};
        vecs[2] = '{16'd7, 12'd0,   16'd7, -1};
        vecs[3] = '{16'd1, 12'd1,   16'd1, 2};
        vecs[4] = '{16'd3, 12'd5,   16'd3, 16};
        vecs[5] = '{16'd2, 12'd4,   16'd2, 9};
        vecs[6] = '{16'd1, 12'hFFF, 16'd1, 4096};
        sdiv = '{16'd100, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        scnt = '{12'd10, 12'd1, 12'd2, 12'd1, 12'd1, 12'd2};

        // Reset values
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_reset", div_reset, 1);
        check("rst_div", div_divide_by, 1);
        check("rst_level", fifo_level, 0);
        check("rst_ready", in_ready, 1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
            tick();
        end

        // Back-to-back steps, queue fill and full-queue push/pop
        do_reset();
        mon_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("seq_ready%0d", i), in_ready, 1);
            in_divide = sdiv[i];
            in_count  = scnt[i];
            in_valid  = 1'b1;
            tick();
        end
        check("seq_full_ready", in_ready, 0);
        check("seq_full_level", fifo_level, 4);
        in_divide = sdiv[5];
        in_count  = scnt[5];
        n = 0;
        while (!done && n < 1200) begin
            tick();
            n++;
        end
        check("seq_first_done", done, 1);
        check("pushpop_level", fifo_level, 4);
        in_valid = 1'b0;
        n = 0;
        while (done_cnt < 6 && n < 400) begin
            tick();
            n++;
        end
        tick();
        check("seq_done_count", done_cnt, 6);
        check("seq_idle_gaps", gaps, 0);
        check("seq_load_count", load_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < load_q.size())
                check($sformatf("seq_order%0d", i), load_q[i], sdiv[i]);
        end
        check("seq_end_busy", busy, 0);
        check("seq_end_level", fifo_level, 0);
        mon_en = 1'b0;

        // Reset during RUN with two steps queued
        do_reset();
        in_valid = 1'b1;
        in_divide = 16'd3; in_count = 12'd4; tick();
        in_divide = 16'd2; in_count = 12'd2; tick();
        in_divide = 16'd5; in_count = 12'd1; tick();
        in_valid = 1'b0;
        n = 0;
        while (div_reset && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) tick();
        check("mid_run_busy", busy, 1);
        check("mid_run_level", fifo_level, 2);
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_div_reset", div_reset, 1);
        check("arst_div", div_divide_by, 1);
        check("arst_level", fifo_level, 0);
        check("arst_ready", in_ready, 1);
        tick();
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done || busy) bad++;
        end
        check("arst_no_done", bad, 0);

`ifdef DIVSEQ_ABORT_EN
        // Abort during RUN with three steps queued; simultaneous push dropped
        do_reset();
        in_valid = 1'b1;
        in_divide = 16'd3; in_count = 12'd4; tick();
        in_divide = 16'd2; in_count = 12'd2; tick();
        tick();
        tick();
        in_valid = 1'b0;
        n = 0;
        while (div_reset && n < 10) begin
            tick();
            n++;
        end
        tick();
        check("abort_pre_level", fifo_level, 3);
        abort = 1'b1;
        in_valid = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_level", fifo_level, 0);
        check("abort_div_reset", div_reset, 1);
        check("abort_done", done, 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) bad++;
        end
        check("abort_no_done", bad, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
